cache_fill_fsm: RTL and testbench

Miss-handling controller that sits directly upstream of the cache metadata array and the cache data array. On a cache miss it fetches one 16-byte block (eight 16-bit words) from pipelined main memory and writes each returned word into the data array. It then writes the new metadata byte (valid bit plus tag) into the metadata array. The cache is stalled while the block is busy.

---
 rtl/cache_fill_fsm.sv | 75 +++++++
 tb/tb_cache_fill_fsm.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_fsm.sv
// rtl/cache_fill_fsm.sv - cache miss fill controller: 8-word block fetch, data-array word writes, metadata write
// Issue and receive sides run independently; completion is signalled combinationally on the 8th valid beat.
module cache_fill_fsm #(
  parameter int ADDR_W  = 16,
  parameter int WORDS   = 8,
  parameter int TAG_LSB = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              memory_data_valid,
  output logic              fsm_busy,
  output logic              mem_read_en,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic [WORDS-1:0]  word_enable,
  output logic              write_tag_array,
  output logic [7:0]        meta_data_out,
  output logic              fill_done
);

  typedef enum logic {IDLE, FILL} state_t;

  state_t            state_q;
  logic [3:0]        issue_cnt_q;
  logic [3:0]        recv_cnt_q;
  logic [ADDR_W-1:0] base_q;

  logic in_fill;
  logic issuing;
  logic beat;
  logic last_beat;

  // Counters saturate at 8, so bit 3 alone marks "all eight done".
  assign in_fill   = (state_q == FILL);
  assign issuing   = in_fill && !issue_cnt_q[3];
  assign beat      = in_fill && memory_data_valid && !recv_cnt_q[3];
  assign last_beat = beat && (recv_cnt_q == 4'd7);

  assign fsm_busy         = in_fill;
  assign mem_read_en      = issuing;
  assign memory_address   = issuing ? (base_q + ADDR_W'({issue_cnt_q[2:0], 1'b0})) : '0;
  assign write_data_array = beat;
  assign word_enable      = beat ? (WORDS'(1) << recv_cnt_q[2:0]) : '0;
  assign write_tag_array  = last_beat;
  assign fill_done        = last_beat;
  assign meta_data_out    = last_beat ? {1'b1, base_q[ADDR_W-1:TAG_LSB]} : 8'h00;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      issue_cnt_q <= 4'd0;
      recv_cnt_q  <= 4'd0;
      base_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (miss_detected) begin
            base_q      <= miss_address & ~ADDR_W'(4'hF);
            issue_cnt_q <= 4'd0;
            recv_cnt_q  <= 4'd0;
            state_q     <= FILL;
          end
        end
        FILL: begin
          if (issuing) issue_cnt_q <= issue_cnt_q + 4'd1;
          if (beat) recv_cnt_q <= recv_cnt_q + 4'd1;
          if (last_beat) state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb/tb_cache_fill_fsm.sv - self-checking bench for cache_fill_fsm
// Table vectors, directed multi-cycle sequences and a queue-based reference model under random stimulus.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic        fsm_busy;
  logic        mem_read_en;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [7:0]  word_enable;
  logic        write_tag_array;
  logic [7:0]  meta_data_out;
  logic        fill_done;

  always #5 clk = ~clk;

  cache_fill_fsm dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .fsm_busy          (fsm_busy),
    .mem_read_en       (mem_read_en),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .word_enable       (word_enable),
    .write_tag_array   (write_tag_array),
    .meta_data_out     (meta_data_out),
    .fill_done         (fill_done)
  );

  typedef struct packed {
    logic        r;
    logic        m;
    logic [15:0] a;
    logic        v;
    logic        busy;
    logic        rd;
    logic [15:0] maddr;
    logic        wr;
    logic [7:0]  we;
    logic        tag;
    logic [7:0]  meta;
    logic        done;
  } vec_t;

  vec_t vec [14];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a fill is a list of pending request addresses and pending word selects.
  logic        m_busy = 1'b0;
  logic [15:0] m_base;
  logic [15:0] addr_q [$];
  logic [7:0]  we_q [$];

  logic [36:0] last_got;
  int          cyc;
  int          wr_cnt;
  int          tag_cnt;
  int          done_cnt;
  int          last_tag_cyc;
  logic [7:0]  metas [$];
  logic [7:0]  we_seen [$];
  int          idle_cyc [$];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic clear_stats();
    cyc = 0; wr_cnt = 0; tag_cnt = 0; done_cnt = 0; last_tag_cyc = -1;
    metas.delete(); we_seen.delete(); idle_cyc.delete();
  endtask

  task automatic step(input logic r, input logic m, input logic [15:0] a, input logic v);
    logic        e_busy, e_rd, e_wr, e_tag, e_done, fin;
    logic [15:0] e_addr;
    logic [7:0]  e_we, e_meta;
    rst = r; miss_detected = m; miss_address = a; memory_data_valid = v;
    @(negedge clk);
    last_got = {fsm_busy, mem_read_en, memory_address, write_data_array, word_enable,
                write_tag_array, meta_data_out, fill_done};
    e_busy = 0; e_rd = 0; e_addr = 0; e_wr = 0; e_we = 0; e_tag = 0; e_meta = 0; e_done = 0; fin = 0;
    if (m_busy) begin
      e_busy = 1;
      if (addr_q.size() > 0) begin e_rd = 1; e_addr = addr_q.pop_front(); end
      if (v && we_q.size() > 0) begin
        e_wr = 1;
        e_we = we_q.pop_front();
        if (we_q.size() == 0) begin
          e_tag = 1; e_done = 1; e_meta = {1'b1, m_base[15:9]}; fin = 1;
        end
      end
    end
    chk($sformatf("model_c%0d", cyc), 64'(last_got),
        64'({e_busy, e_rd, e_addr, e_wr, e_we, e_tag, e_meta, e_done}));
    if (write_data_array === 1'b1) begin wr_cnt++; we_seen.push_back(word_enable); end
    if (write_tag_array === 1'b1) begin tag_cnt++; last_tag_cyc = cyc; metas.push_back(meta_data_out); end
    if (fill_done === 1'b1) done_cnt++;
    if (fsm_busy === 1'b0) idle_cyc.push_back(cyc);
    if (!r) begin
      m_busy = 0; addr_q.delete(); we_q.delete();
    end else if (!m_busy) begin
      if (m) begin
        m_busy = 1;
        m_base = a & 16'hFFF0;
        for (int k = 0; k < 8; k++) begin
          addr_q.push_back(m_base + 16'(2 * k));
          we_q.push_back(8'h01 << k);
        end
      end
    end else if (fin) begin
      m_busy = 0; addr_q.delete();
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int snap;
    logic ok;
    // Single fill of 16'h1A36 with memory latency 4: requests cycles 1-8, data 5-12.
    vec[0]  = '{1'b1, 1'b1, 16'h1A36, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    vec[1]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h1A30, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    vec[2]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h1A32, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    vec[3]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h1A34, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    vec[4]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h1A36, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    vec[5]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h1A38, 1'b1, 8'h01, 1'b0, 8'h00, 1'b0};
    vec[6]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h1A3A, 1'b1, 8'h02, 1'b0, 8'h00, 1'b0};
    vec[7]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h1A3C, 1'b1, 8'h04, 1'b0, 8'h00, 1'b0};
    vec[8]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h1A3E, 1'b1, 8'h08, 1'b0, 8'h00, 1'b0};
    vec[9]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 8'h10, 1'b0, 8'h00, 1'b0};
    vec[10] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 8'h20, 1'b0, 8'h00, 1'b0};
    vec[11] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 8'h40, 1'b0, 8'h00, 1'b0};
    vec[12] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 8'h80, 1'b1, 8'h8D, 1'b1};
    vec[13] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};

    rst = 1'b0; miss_detected = 1'b0; miss_address = 16'h0; memory_data_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    clear_stats();
    step(1'b1, 1'b0, 16'hFFFF, 1'b1);
    chk("reset_state", 64'(last_got), 64'd0);

    clear_stats();
    for (int i = 0; i < 14; i++) begin
      step(vec[i].r, vec[i].m, vec[i].a, vec[i].v);
      chk($sformatf("tbl_c%0d", i), 64'(last_got),
          64'({vec[i].busy, vec[i].rd, vec[i].maddr, vec[i].wr, vec[i].we, vec[i].tag, vec[i].meta, vec[i].done}));
    end

    // Gapped data beats 1,0,1,0... from cycle 5; the 8th valid beat lands on cycle 19.
    clear_stats();
    step(1'b1, 1'b1, 16'h1A36, 1'b0);
    for (int c = 1; c <= 25; c++) step(1'b1, 1'b0, 16'h0, (c >= 5) && ((c - 5) % 2 == 0));
    chk("gap_writes", 64'(wr_cnt), 64'd8);
    ok = (we_seen.size() == 8);
    for (int k = 0; k < we_seen.size() && k < 8; k++) if (we_seen[k] !== (8'h01 << k)) ok = 0;
    chk("gap_order", 64'(ok), 64'd1);
    chk("gap_tag_cycle", 64'(last_tag_cyc), 64'd19);
    chk("gap_done_cnt", 64'(done_cnt), 64'd1);

    // Second miss held from cycle 3 is ignored until the first IDLE cycle (13).
    clear_stats();
    step(1'b1, 1'b1, 16'h1A36, 1'b0);
    for (int c = 1; c <= 13; c++) step(1'b1, c >= 3, 16'h5557, (c >= 5) && (c <= 12));
    for (int c = 14; c <= 27; c++) step(1'b1, 1'b0, 16'h0, (c >= 18) && (c <= 25));
    chk("busy_tag_cnt", 64'(tag_cnt), 64'd2);
    chk("busy_meta0", 64'(metas.size() > 0 ? metas[0] : 8'h00), 64'h8D);
    chk("busy_meta1", 64'(metas.size() > 1 ? metas[1] : 8'h00), 64'hAA);
    chk("busy_last_tag", 64'(last_tag_cyc), 64'd25);

    // Stray beats in IDLE, then a 9th beat right after completion.
    clear_stats();
    for (int c = 0; c < 5; c++) step(1'b1, 1'b0, 16'h0, 1'b1);
    chk("stray_idle_writes", 64'(wr_cnt), 64'd0);
    step(1'b1, 1'b1, 16'h1A36, 1'b0);
    for (int c = 1; c <= 13; c++) step(1'b1, 1'b0, 16'h0, c >= 5);
    chk("excess_writes", 64'(wr_cnt), 64'd8);
    chk("excess_done", 64'(done_cnt), 64'd1);

    // Reset asserted at cycle 7 abandons the fill.
    clear_stats();
    step(1'b1, 1'b1, 16'h1A36, 1'b0);
    for (int c = 1; c <= 7; c++) step(c != 7, 1'b0, 16'h0, c >= 5);
    snap = wr_cnt;
    step(1'b1, 1'b0, 16'h0, 1'b1);
    chk("rst_c8_outputs", 64'(last_got), 64'd0);
    for (int c = 9; c <= 16; c++) step(1'b1, 1'b0, 16'h0, 1'b1);
    chk("rst_no_writes", 64'(wr_cnt - snap), 64'd0);
    chk("rst_no_tag", 64'(tag_cnt), 64'd0);
    chk("rst_no_done", 64'(done_cnt), 64'd0);

    // Back-to-back: miss held continuously, fills start at edges 0 and 13.
    clear_stats();
    for (int c = 0; c <= 26; c++)
      step(1'b1, 1'b1, 16'h1A36 + 16'(c), ((c >= 5) && (c <= 12)) || ((c >= 18) && (c <= 25)));
    chk("b2b_writes", 64'(wr_cnt), 64'd16);
    chk("b2b_tags", 64'(tag_cnt), 64'd2);
    chk("b2b_idle_cnt", 64'(idle_cyc.size()), 64'd3);
    chk("b2b_idle_13", 64'(idle_cyc.size() > 1 ? idle_cyc[1] : -1), 64'd13);

    // Random traffic against the reference model.
    clear_stats();
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 99) != 0, $urandom_range(0, 3) == 0, 16'($urandom), 1'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
